// File: rtl/fp_post_normalizer_if.sv
// fp_post_normalizer_if: operand/result handshake bundle for the post-addition normalizer
interface fp_post_normalizer_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic [EXP_W-1:0]        in_exp;
  logic [MANT_W+1:0]       in_mant;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+MANT_W:0]   out_result;
  logic                    out_zero;
  logic                    out_overflow;
  logic                    out_underflow;
  logic                    busy;
  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_overflow, out_underflow, busy
  );
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_overflow, out_underflow, busy
  );
endinterface

// File: rtl/fp_post_normalizer.sv
// fp_post_normalizer: iterative post-add normalizer packing {sign, exp, frac} with zero/overflow/underflow flags
// Ports: clk, rst_n (async, active-low); bus.slave carries the in_* operand handshake,
// the out_* result handshake with flags, and busy (state not IDLE).
module fp_post_normalizer #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input logic                 clk,
  input logic                 rst_n,
  fp_post_normalizer_if.slave bus
);
  localparam int RW = 1 + EXP_W + MANT_W;
  localparam int MW = MANT_W + 2;
  localparam logic [EXP_W-1:0] EMAX = {EXP_W{1'b1}};
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t            r_state, w_state;
  logic              r_sign, w_sign;
  logic [EXP_W-1:0]  r_exp, w_exp;
  logic [MW-1:0]     r_mant, w_mant;
  logic [RW-1:0]     r_result, w_result;
  logic              r_zero, w_zero, r_ovf, w_ovf, r_unf, w_unf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_sign   <= w_sign;
      r_exp    <= w_exp;
      r_mant   <= w_mant;
      r_result <= w_result;
      r_zero   <= w_zero;
      r_ovf    <= w_ovf;
      r_unf    <= w_unf;
    end
  end
  // One rule per NORM cycle, first match wins; only the plain left shift stays in NORM.
  always_comb begin
    w_state  = r_state;
    w_sign   = r_sign;
    w_exp    = r_exp;
    w_mant   = r_mant;
    w_result = r_result;
    w_zero   = r_zero;
    w_ovf    = r_ovf;
    w_unf    = r_unf;
    case (r_state)
      IDLE: if (bus.in_valid) begin
        w_state = NORM;
        w_sign  = bus.in_sign;
        w_exp   = bus.in_exp;
        w_mant  = bus.in_mant;
      end
      NORM: begin
        w_state = DONE;
        w_zero  = 1'b0;
        w_ovf   = 1'b0;
        w_unf   = 1'b0;
        if (r_exp == EMAX || (r_mant[MW-1] && r_exp >= EMAX - 1'b1)) begin
          w_result = {r_sign, EMAX, {MANT_W{1'b0}}};
          w_ovf    = 1'b1;
        end else if (r_mant == '0) begin
          w_result = '0;
          w_zero   = 1'b1;
        end else if (r_mant[MW-1]) begin
          // carry-out: drop the LSB (truncation) and bump the exponent
          w_result = {r_sign, r_exp + 1'b1, r_mant[MANT_W:1]};
        end else if (r_exp == '0) begin
          w_result = {r_sign, {(RW-1){1'b0}}};
          w_unf    = 1'b1;
        end else if (r_mant[MANT_W]) begin
          w_result = {r_sign, r_exp, r_mant[MANT_W-1:0]};
        end else if (r_exp == EXP_W'(1)) begin
          w_result = {r_sign, {(RW-1){1'b0}}};
          w_unf    = 1'b1;
        end else begin
          w_state = NORM;
          w_mant  = r_mant << 1;
          w_exp   = r_exp - 1'b1;
        end
      end
      DONE: w_state = bus.out_ready ? IDLE : DONE;
      default: w_state = IDLE;
    endcase
  end
  assign bus.in_ready      = r_state == IDLE;
  assign bus.out_valid     = r_state == DONE;
  assign bus.busy          = r_state != IDLE;
  assign bus.out_result    = r_result;
  assign bus.out_zero      = r_zero;
  assign bus.out_overflow  = r_ovf;
  assign bus.out_underflow = r_unf;
endmodule

// File: tb/tb_fp_post_normalizer.sv
// tb_fp_post_normalizer: directed-vector self-checking bench for fp_post_normalizer
module tb_fp_post_normalizer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  fp_post_normalizer_if bus ();
  fp_post_normalizer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask
  task automatic idle_chk(input string tag);
    chk(tag, {bus.in_ready, bus.out_valid, bus.busy, bus.out_zero, bus.out_overflow,
              bus.out_underflow, bus.out_result}, {6'b100000, 32'h0});
  endtask
  task automatic issue(input logic s, input logic [7:0] e, input logic [24:0] m);
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_exp   = '0;
    bus.in_mant  = '0;
  endtask
  // fl = {zero, overflow, underflow}; lat_want counts edges from accept to out_valid
  task automatic run(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m,
                     input logic [31:0] res, input logic [2:0] fl, input int lat_want,
                     input bit release_out = 1'b1);
    int lat;
    chk({tag, "/in_ready"}, bus.in_ready, 1);
    issue(s, e, m);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    chk({tag, "/lat"}, lat, lat_want);
    chk({tag, "/result"}, bus.out_result, res);
    chk({tag, "/flags"}, {bus.out_zero, bus.out_overflow, bus.out_underflow}, fl);
    if (release_out) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    idle_chk("reset");
    rst_n = 1'b1;
    @(negedge clk);
    run("norm",      1'b0, 8'd130, 25'h0800000, 32'h41000000, 3'b000, 1);
    run("carry",     1'b0, 8'd127, 25'h1800000, 32'h40400000, 3'b000, 1);
    run("maxshift",  1'b0, 8'd127, 25'h0000001, 32'h34000000, 3'b000, 24);
    run("unf_shift", 1'b1, 8'd3,   25'h0000100, 32'h80000000, 3'b001, 3);
    run("zero_neg",  1'b1, 8'd50,  25'h0000000, 32'h00000000, 3'b100, 1);
    run("ovf_carry", 1'b0, 8'd254, 25'h1000000, 32'h7F800000, 3'b010, 1);
    run("ovf_255",   1'b0, 8'd255, 25'h0ABCDEF, 32'h7F800000, 3'b010, 1);
    run("ovf_255z",  1'b1, 8'd255, 25'h0000000, 32'hFF800000, 3'b010, 1);
    run("carry_e0",  1'b0, 8'd0,   25'h1000000, 32'h00800000, 3'b000, 1);
    run("unf_e0",    1'b0, 8'd0,   25'h0800000, 32'h00000000, 3'b001, 1);
    run("norm_e1",   1'b1, 8'd1,   25'h0800000, 32'h80800000, 3'b000, 1);
    run("shift1",    1'b0, 8'd10,  25'h0400000, 32'h04800000, 3'b000, 2);
    run("trunc",     1'b0, 8'd100, 25'h1000003, 32'h32800001, 3'b000, 1);
    run("carry_253", 1'b0, 8'd253, 25'h1FFFFFF, 32'h7F7FFFFF, 3'b000, 1);
    run("bp", 1'b1, 8'd254, 25'h1000000, 32'hFF800000, 3'b010, 1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_exp   = 8'd130;
    bus.in_mant  = 25'h0800000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp/hold", {bus.out_valid, bus.in_ready, bus.busy, bus.out_zero, bus.out_overflow,
                      bus.out_underflow, bus.out_result}, {6'b101010, 32'hFF800000});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp/release", {bus.in_ready, bus.out_valid}, 2'b10);
    issue(1'b0, 8'd127, 25'h0000001);
    repeat (4) @(negedge clk);
    chk("rst/busy_before", {bus.busy, bus.in_ready}, 2'b10);
    #2 rst_n = 1'b0;
    #1 idle_chk("rst/mid_norm");
    @(negedge clk);
    idle_chk("rst/held");
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk("rst/after");
    run("post_rst", 1'b0, 8'd130, 25'h0800000, 32'h41000000, 3'b000, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fp_post_normalizer.md
# fp_post_normalizer

Sequential IEEE-754 single-precision post-addition normalizer for the Maxnet floating-point datapath. It takes the raw, un-normalized mantissa sum produced after exponent alignment and addition, and brings the result back into normalized form. Normalization is a single right shift on carry-out, or iterative one-bit left shifts with exponent decrement. It packs the 32-bit result, flags overflow, underflow and zero, and hands the result downstream over a valid/ready handshake.

## Interface
- `EXP_W`, default 8: exponent width.
- `MANT_W`, default 23: stored fraction width. Raw input mantissa is `MANT_W+2` bits.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand valid.
- `in_ready` output 1: block can accept an operand.
- `in_sign` input 1: sign of the sum.
- `in_exp` input `EXP_W`: common (aligned) exponent.
- `in_mant` input `MANT_W+2` (25): raw sum. Bit 24 is carry-out, bit 23 is hidden-bit position, bits 22:0 are fraction.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_result` output 32: packed `{sign, exp[7:0], frac[22:0]}`.
- `out_zero` output 1: exact-zero result.
- `out_overflow` output 1: result saturated to infinity.
- `out_underflow` output 1: result flushed to zero.
- `busy` output 1: state is not IDLE.

## Operation
- State machine has three states: IDLE, NORM, DONE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE). Both are decoded from the registered state.
- **IDLE:** on `in_valid & in_ready`, register sign, exponent and mantissa, then go to NORM.
- **NORM:** each cycle evaluates exactly one rule. The first match in this priority order wins:
  1. exp == 255: overflow. Result `{sign, 8'hFF, 23'h0}`. Go to DONE.
  2. mant == 0: zero. Result `32'h00000000` (sign forced to +). Go to DONE.
  3. mant[24] set:
     - If exp ≥ 254: overflow. Result as rule 1.
     - Otherwise: mant >>= 1 (LSB truncated, no rounding), exp += 1. Go to DONE.
  4. exp == 0: underflow. Result `{sign, 31'h0}`. Go to DONE.
  5. mant[23] set: normalized. Result `{sign, exp, mant[22:0]}`. Go to DONE.
  6. exp == 1: underflow. Result as rule 4.
  7. Otherwise: mant <<= 1, exp -= 1. Stay in NORM.
- **DONE:** hold `out_result` and the flags stable. On `out_ready`, go to IDLE.
- Flags are mutually exclusive. All are 0 for a normal result.
- No denormal outputs are ever produced. Rounding is truncation only.

## Timing
- Reset values (asynchronous): state IDLE, `in_ready`=1, `out_valid`=0, `out_result`=0, all flags 0, `busy`=0.
- Latency: for an operand accepted at edge E0 that needs k left shifts, `out_valid` rises after edge E0+k+1.
  - Minimum latency: 1 cycle.
  - Maximum latency: 24 cycles (mant = 1, k = 23).
- No new operand is accepted while in NORM or DONE. Minimum issue interval is k+3 cycles.
- Back-pressure: `out_ready` low keeps DONE indefinitely. Outputs do not change.
- `in_valid` and input fields are ignored outside IDLE. No input buffering.
- Reset asserted mid-NORM or mid-DONE: the operand is discarded and all outputs return to their reset values immediately.
- `out_ready` high while not in DONE has no effect.

## Test plan
- Normalized input: sign 0, exp 130, mant 25'h0800000.
  - Requires `out_result` 32'h41000000 one cycle after accept, no flags.
- Carry-out: exp 127, mant 25'h1800000.
  - Requires 32'h40400000, latency 1, no flags.
- Maximum left shift: exp 127, mant 25'h0000001.
  - Requires 32'h34000000 (exp 104), `out_valid` 24 cycles after accept.
- Underflow and zero:
  - sign 1, exp 3, mant 25'h0000100: requires 32'h80000000 with `out_underflow`=1 after 3 cycles.
  - mant 0: requires 32'h00000000 with `out_zero`=1.
- Overflow: exp 254, mant 25'h1000000, and separately exp 255 with any mantissa.
  - Requires 32'h7F800000 with `out_overflow`=1.
- Back-pressure and reset:
  - Hold `out_ready`=0 for 10 cycles: `out_result`, flags and `out_valid` must stay stable, and `in_ready` must stay 0.
  - Pulse `rst_n` low mid-NORM: all outputs return to reset values, then the next operand completes correctly.
